// File: rtl/i2c_arb_pkg.sv
// Shared types and helpers for the I2C master arbiter.
// State encoding, default widths and the round-robin pick function.
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int MAX_REQ       = 8;
   localparam int DEF_N_REQ     = 2;
   localparam int DEF_WDATA_W   = 32;
   localparam int DEF_RDATA_W   = 8;
   localparam int DEF_CNT_W     = 8;
   localparam int DEF_TIMEOUT   = 4095;

   // First set bit of req at or after ptr, wrapping within n requesters.
   function automatic logic [MAX_REQ-1:0] rr_onehot(
      input logic [MAX_REQ-1:0] req,
      input logic [2:0]         ptr,
      input int                 n
   );
      logic [MAX_REQ-1:0] g;
      logic [2:0]         k;
      logic               found;
      g     = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         k = 3'((int'(ptr) + i) % n);
         if (i < n && !found && req[k]) begin
            g[k]  = 1'b1;
            found = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant plus valid flag.
// Reusable by any shared-resource arbiter with up to 8 requesters.
module rr_pick
   import i2c_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          valid
);

   logic [MAX_REQ-1:0] req_x;
   logic [MAX_REQ-1:0] gnt_x;
   logic               unused_hi;

   assign req_x     = MAX_REQ'(req);
   assign gnt_x     = rr_onehot(req_x, 3'(ptr), N);
   assign gnt       = gnt_x[N-1:0];
   assign valid     = |req;
   assign unused_hi = ^gnt_x;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin sharing of one uii2c-style master among N_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to abort launches the master never accepts.
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int WDATA_W = DEF_WDATA_W,
   parameter int RDATA_W = DEF_RDATA_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                     clk_i,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_i,
   input  logic [N_REQ*WDATA_W-1:0] req_wdata_i,
   input  logic [N_REQ*CNT_W-1:0]   req_wcnt_i,
   input  logic [N_REQ*CNT_W-1:0]   req_rcnt_i,
   input  logic [N_REQ-1:0]         req_mode_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [N_REQ-1:0]         done_o,
   output logic [N_REQ-1:0]         err_o,
   output logic [RDATA_W-1:0]       rd_data_o,
   output logic                     m_en_o,
   output logic [WDATA_W-1:0]       m_wdata_o,
   output logic [CNT_W-1:0]         m_wcnt_o,
   output logic [CNT_W-1:0]         m_rcnt_o,
   output logic                     m_mode_o,
   input  logic                     m_busy_i,
   input  logic [RDATA_W-1:0]       m_rdata_i
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           state_q;
   state_t           state_d;
   logic [N_REQ-1:0] pick_oh;
   logic             pick_vld;
   logic [PW-1:0]    pick_idx;
   logic [PW-1:0]    own_q;
   logic [PW-1:0]    ptr_q;
   logic [PW-1:0]    ptr_nxt;
   logic [N_REQ-1:0] own_oh;
   logic             start;
   logic             fin;
   logic             tmo;

   rr_pick #(
      .N  (N_REQ),
      .PW (PW)
   ) u_pick (
      .req   (req_i),
      .ptr   (ptr_q),
      .gnt   (pick_oh),
      .valid (pick_vld)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_oh[i]) pick_idx = PW'(i);
      end
   end

   assign start   = (state_q == IDLE) && pick_vld && !m_busy_i;
   assign fin     = (state_q == BUSY) && !m_busy_i;
   assign ptr_nxt = (own_q == PW'(N_REQ - 1)) ? '0 : own_q + 1'b1;
   assign own_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << own_q;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0]    cnt_q;
   logic [N_REQ-1:0] err_q;

   assign tmo = (state_q == LAUNCH) && !m_busy_i
             && (cnt_q == TW'(TIMEOUT - 1));

   // Counts only while LAUNCH persists; any state entry restarts it.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= '0;
      end else begin
         if (state_q == LAUNCH && state_d == LAUNCH) cnt_q <= cnt_q + 1'b1;
         else                                        cnt_q <= '0;
         err_q <= tmo ? own_oh : '0;
      end
   end

   assign err_o = err_q;
`else
   localparam int unused_tmo = TIMEOUT;

   assign tmo   = 1'b0;
   assign err_o = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = LAUNCH;
         LAUNCH: begin
            if (m_busy_i) state_d = BUSY;
            else if (tmo) state_d = IDLE;
         end
         BUSY:    if (!m_busy_i) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Payload is latched at grant so requesters may move on immediately.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         m_wdata_o <= '0;
         m_wcnt_o  <= '0;
         m_rcnt_o  <= '0;
         m_mode_o  <= 1'b0;
         rd_data_o <= '0;
         own_q     <= '0;
         ptr_q     <= '0;
      end else begin
         if (start) begin
            m_wdata_o <= req_wdata_i[pick_idx*WDATA_W +: WDATA_W];
            m_wcnt_o  <= req_wcnt_i[pick_idx*CNT_W +: CNT_W];
            m_rcnt_o  <= req_rcnt_i[pick_idx*CNT_W +: CNT_W];
            m_mode_o  <= req_mode_i[pick_idx];
            own_q     <= pick_idx;
         end
         if (fin) rd_data_o <= m_rdata_i;
         if (state_q == DONE || tmo) ptr_q <= ptr_nxt;
      end
   end

   always_comb begin
      gnt_o  = '0;
      done_o = '0;
      m_en_o = 1'b0;
      unique case (state_q)
         LAUNCH: begin
            gnt_o  = own_oh;
            m_en_o = 1'b1;
         end
         BUSY:    gnt_o  = own_oh;
         DONE:    done_o = own_oh;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter with a behavioural master model.
// Covers I2C_ARB_TIMEOUT_EN when that macro is defined.
module tb_i2c_bus_arbiter;

   localparam int N  = 2;
   localparam int WW = 32;
   localparam int RW = 8;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    req = '0;
   logic [N*WW-1:0] wdata = '0;
   logic [N*CW-1:0] wcnt = '0;
   logic [N*CW-1:0] rcnt = '0;
   logic [N-1:0]    mode = '0;
   logic [N-1:0]    gnt;
   logic [N-1:0]    done;
   logic [N-1:0]    err;
   logic [RW-1:0]   rd_data;
   logic            m_en;
   logic [WW-1:0]   m_wdata;
   logic [CW-1:0]   m_wcnt;
   logic [CW-1:0]   m_rcnt;
   logic            m_mode;
   logic            m_busy = 1'b0;
   logic [RW-1:0]   m_rdata = '0;

   int passed = 0;
   int total = 0;

   // Master model knobs
   int          dly = 2;
   int          blen = 10;
   bit          mute = 1'b0;
   logic [RW-1:0] nxt_rd = '0;
   int          mst = 0;
   int          mcnt = 0;

   i2c_bus_arbiter #(
      .N_REQ   (N),
      .WDATA_W (WW),
      .RDATA_W (RW),
      .CNT_W   (CW),
      .TIMEOUT (16)
   ) dut (
      .clk_i       (clk),
      .rst_n       (rst_n),
      .req_i       (req),
      .req_wdata_i (wdata),
      .req_wcnt_i  (wcnt),
      .req_rcnt_i  (rcnt),
      .req_mode_i  (mode),
      .gnt_o       (gnt),
      .done_o      (done),
      .err_o       (err),
      .rd_data_o   (rd_data),
      .m_en_o      (m_en),
      .m_wdata_o   (m_wdata),
      .m_wcnt_o    (m_wcnt),
      .m_rcnt_o    (m_rcnt),
      .m_mode_o    (m_mode),
      .m_busy_i    (m_busy),
      .m_rdata_i   (m_rdata)
   );

   // uii2c-like master: accepts en, raises busy after dly, drops after blen.
   always @(posedge clk) begin
      #2;
      if (mst == 0) begin
         if (m_en && !mute) begin
            mcnt = dly;
            mst  = 1;
         end
      end else if (mst == 1) begin
         if (mcnt == 0) begin
            m_busy = 1'b1;
            mcnt   = blen;
            mst    = 2;
         end else mcnt--;
      end else begin
         if (mcnt == 0) begin
            m_busy  = 1'b0;
            m_rdata = nxt_rd;
            mst     = 0;
         end else mcnt--;
      end
   end

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (gnt != '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (done != '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_busy();
      for (int i = 0; i < 50 && !m_busy; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({gnt, done, err, m_en, m_mode} !== '0) begin
         $display("FAIL reset_ctl: got gnt=%b done=%b err=%b en=%b mode=%b want 0",
                  gnt, done, err, m_en, m_mode);
      end else passed++;
      total++;
      if ({m_wdata, m_wcnt, m_rcnt, rd_data} !== '0) begin
         $display("FAIL reset_data: got wdata=%h wcnt=%h rcnt=%h rd=%h want 0",
                  m_wdata, m_wcnt, m_rcnt, rd_data);
      end else passed++;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (gnt !== '0) $display("FAIL idle_nogrant: got %b want 00", gnt);
      else passed++;
   endtask

   task automatic test_single_write();
      bit ok;
      int nd;
      wdata[31:0] = 32'h1A300878;
      wcnt[7:0]   = 8'd4;
      rcnt[7:0]   = 8'd0;
      mode[0]     = 1'b0;
      dly  = 2;
      blen = 100;
      @(negedge clk);
      req = 2'b01;
      @(negedge clk);
      total++;
      if (gnt !== 2'b01 || m_en !== 1'b1) begin
         $display("FAIL sw_grant: got gnt=%b en=%b want 01/1", gnt, m_en);
      end else passed++;
      total++;
      if (m_wdata !== 32'h1A300878 || m_wcnt !== 8'd4) begin
         $display("FAIL sw_payload: got %h/%0d want 1a300878/4", m_wdata, m_wcnt);
      end else passed++;
      wait_busy();
      @(negedge clk);
      total++;
      if (m_en !== 1'b0 || gnt !== 2'b01) begin
         $display("FAIL sw_busy: got en=%b gnt=%b want 0/01", m_en, gnt);
      end else passed++;
      wait_done(ok);
      total++;
      if (!ok || done !== 2'b01 || gnt !== 2'b00) begin
         $display("FAIL sw_done: got done=%b gnt=%b want 01/00", done, gnt);
      end else passed++;
      req = '0;
      nd  = 0;
      repeat (20) begin
         @(negedge clk);
         if (done != '0) nd++;
      end
      total++;
      if (nd != 0 || gnt !== '0) begin
         $display("FAIL sw_once: got extra done=%0d gnt=%b want 0/00", nd, gnt);
      end else passed++;
   endtask

   task automatic test_simultaneous();
      bit ok;
      do_reset();
      wdata = {32'hBBBB0001, 32'hAAAA0000};
      dly   = 1;
      blen  = 8;
      req   = 2'b11;
      wait_gnt(ok);
      total++;
      if (!ok || gnt !== 2'b01 || m_wdata !== 32'hAAAA0000) begin
         $display("FAIL sim_first: got gnt=%b wdata=%h want 01/aaaa0000", gnt, m_wdata);
      end else passed++;
      wait_done(ok);
      total++;
      if (!ok || done !== 2'b01) $display("FAIL sim_done0: got %b want 01", done);
      else passed++;
      req[0] = 1'b0;
      @(negedge clk);
      total++;
      if (gnt !== 2'b00) $display("FAIL sim_turnaround: got %b want 00", gnt);
      else passed++;
      wait_gnt(ok);
      total++;
      if (!ok || gnt !== 2'b10 || m_wdata !== 32'hBBBB0001) begin
         $display("FAIL sim_second: got gnt=%b wdata=%h want 10/bbbb0001", gnt, m_wdata);
      end else passed++;
      wait_done(ok);
      total++;
      if (!ok || done !== 2'b10) $display("FAIL sim_done1: got %b want 10", done);
      else passed++;
      req = '0;
   endtask

   task automatic test_fairness();
      bit ok;
      do_reset();
      blen = 12;
      req  = 2'b01;
      wait_gnt(ok);
      wait_busy();
      req[1] = 1'b1;
      wait_done(ok);
      total++;
      if (!ok || done !== 2'b01) $display("FAIL fair_done0: got %b want 01", done);
      else passed++;
      wait_gnt(ok);
      total++;
      if (!ok || gnt !== 2'b10) $display("FAIL fair_next: got %b want 10", gnt);
      else passed++;
      wait_done(ok);
      req[1] = 1'b0;
      wait_gnt(ok);
      total++;
      if (!ok || gnt !== 2'b01) $display("FAIL fair_back: got %b want 01", gnt);
      else passed++;
      wait_done(ok);
      req = '0;
   endtask

   task automatic test_read();
      bit ok;
      mode[1]      = 1'b1;
      rcnt[15:8]   = 8'd1;
      nxt_rd       = 8'h56;
      blen         = 10;
      req          = 2'b10;
      wait_gnt(ok);
      total++;
      if (!ok || gnt !== 2'b10 || m_mode !== 1'b1 || m_rcnt !== 8'd1) begin
         $display("FAIL rd_grant: got gnt=%b mode=%b rcnt=%0d want 10/1/1", gnt, m_mode, m_rcnt);
      end else passed++;
      wait_done(ok);
      total++;
      if (!ok || done !== 2'b10 || rd_data !== 8'h56) begin
         $display("FAIL rd_data: got done=%b rd=%h want 10/56", done, rd_data);
      end else passed++;
      req    = 2'b01;
      nxt_rd = 8'hAA;
      wait_gnt(ok);
      wait_busy();
      @(negedge clk);
      total++;
      if (rd_data !== 8'h56) $display("FAIL rd_hold: got %h want 56", rd_data);
      else passed++;
      wait_done(ok);
      total++;
      if (!ok || rd_data !== 8'hAA) $display("FAIL rd_next: got %h want aa", rd_data);
      else passed++;
      req  = '0;
      mode = '0;
      rcnt = '0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int nd;
      blen = 30;
      req  = 2'b01;
      wait_gnt(ok);
      wait_done(ok);
      req = 2'b10;
      wait_gnt(ok);
      wait_busy();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (m_en !== 1'b0 || gnt !== '0 || done !== '0 || rd_data !== '0) begin
         $display("FAIL rst_mid: got en=%b gnt=%b done=%b rd=%h want 0",
                  m_en, gnt, done, rd_data);
      end else passed++;
      rst_n = 1'b1;
      req   = 2'b11;
      nd    = 0;
      wait_gnt(ok);
      total++;
      if (!ok || gnt !== 2'b01) $display("FAIL rst_prio: got %b want 01", gnt);
      else passed++;
      wait_done(ok);
      req[0] = 1'b0;
      wait_gnt(ok);
      wait_done(ok);
      req = '0;
   endtask

   task automatic test_random();
      bit            ok;
      logic [N-1:0]  pend;
      logic [N-1:0]  one;
      int            ptr_m;
      int            k;
      logic [WW-1:0] ew[N];
      logic [CW-1:0] ewc[N];
      logic [CW-1:0] erc[N];
      logic          em[N];
      logic [RW-1:0] exp_rd;
      do_reset();
      ptr_m = 0;
      one   = 1;
      for (int r = 0; r < 15; r++) begin
         pend = N'($urandom_range(1, (1 << N) - 1));
         for (int j = 0; j < N; j++) begin
            ew[j]  = $urandom;
            ewc[j] = CW'($urandom);
            erc[j] = CW'($urandom);
            em[j]  = 1'($urandom);
            wdata[j*WW +: WW] = ew[j];
            wcnt[j*CW +: CW]  = ewc[j];
            rcnt[j*CW +: CW]  = erc[j];
            mode[j]           = em[j];
         end
         dly    = $urandom_range(0, 4);
         blen   = $urandom_range(1, 12);
         nxt_rd = RW'($urandom);
         exp_rd = nxt_rd;
         req    = pend;
         while (pend != '0) begin
            k = 0;
            for (int j = N - 1; j >= 0; j--) begin
               if (pend[(ptr_m + j) % N]) k = (ptr_m + j) % N;
            end
            wait_gnt(ok);
            total++;
            if (!ok || gnt !== (one << k)) begin
               $display("FAIL rnd_gnt r%0d: got %b want %b", r, gnt, one << k);
            end else passed++;
            wdata[k*WW +: WW] = $urandom;
            wait_done(ok);
            total++;
            if (!ok || done !== (one << k) || rd_data !== exp_rd) begin
               $display("FAIL rnd_done r%0d: got done=%b rd=%h want %b/%h",
                        r, done, rd_data, one << k, exp_rd);
            end else passed++;
            total++;
            if (m_wdata !== ew[k] || m_wcnt !== ewc[k] || m_rcnt !== erc[k]
                || m_mode !== em[k]) begin
               $display("FAIL rnd_payload r%0d: got %h/%h/%h/%b want %h/%h/%h/%b",
                        r, m_wdata, m_wcnt, m_rcnt, m_mode, ew[k], ewc[k], erc[k], em[k]);
            end else passed++;
            req[k]  = 1'b0;
            pend[k] = 1'b0;
            ptr_m   = (k + 1) % N;
            nxt_rd  = RW'($urandom);
            exp_rd  = nxt_rd;
         end
      end
      req = '0;
   endtask

`ifdef I2C_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int ne;
      int nd;
      do_reset();
      mute = 1'b1;
      req  = 2'b11;
      wait_gnt(ok);
      ne = (m_en === 1'b1) ? 1 : 0;
      nd = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done != '0) nd++;
         if (err != '0) break;
         if (m_en === 1'b1) ne++;
      end
      total++;
      if (err !== 2'b01 || ne != 16 || nd != 0) begin
         $display("FAIL tmo_err: got err=%b en_cycles=%0d done=%0d want 01/16/0", err, ne, nd);
      end else passed++;
      total++;
      if (gnt !== '0 || m_en !== 1'b0) begin
         $display("FAIL tmo_clear: got gnt=%b en=%b want 00/0", gnt, m_en);
      end else passed++;
      req[0] = 1'b0;
      mute   = 1'b0;
      blen   = 5;
      wait_gnt(ok);
      total++;
      if (!ok || gnt !== 2'b10) $display("FAIL tmo_next: got %b want 10", gnt);
      else passed++;
      wait_done(ok);
      total++;
      if (!ok || done !== 2'b10) $display("FAIL tmo_done: got %b want 10", done);
      else passed++;
      req = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_simultaneous();
      test_fairness();
      test_read();
      test_reset_mid();
      test_random();
`ifdef I2C_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one uii2c-style I2C master between N_REQ requesters, e.g. the OV5640 boot-config sequencer and a runtime exposure/AWB register-tweak port.
- Round-robin grants, per-requester done pulses, and read-data return.
- Owns the master's iic_en/wr_data/wr_cnt/rd_cnt/iic_mode inputs; sits between the requesters and the master instance.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- WDATA_W, 32, write payload width (DEVID + up to 3 bytes)
- RDATA_W, 8, read data width
- CNT_W, 8, byte-count width
- TIMEOUT, 4095, cycles allowed for m_busy_i to rise after launch (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset
- req_i  in  N_REQ  per-requester transaction request, level
- req_wdata_i  in  N_REQ*WDATA_W  flattened write payload; requester k occupies [k*WDATA_W +: WDATA_W]
- req_wcnt_i  in  N_REQ*CNT_W  flattened write byte counts
- req_rcnt_i  in  N_REQ*CNT_W  flattened read byte counts
- req_mode_i  in  N_REQ  per-requester iic_mode
- gnt_o  out  N_REQ  one-hot; high for the whole owned transaction
- done_o  out  N_REQ  one-cycle completion pulse
- err_o  out  N_REQ  one-cycle error pulse (optional feature only; tied 0 otherwise)
- rd_data_o  out  RDATA_W  read data; valid in the cycle done_o pulses, then held
- m_en_o  out  1  master iic_en
- m_wdata_o  out  WDATA_W  master wr_data
- m_wcnt_o  out  CNT_W  master wr_cnt
- m_rcnt_o  out  CNT_W  master rd_cnt
- m_mode_o  out  1  master iic_mode
- m_busy_i  in  1  master iic_busy
- m_rdata_i  in  RDATA_W  master rd_data

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk_i.
  - All outputs 0; state IDLE.
  - Round-robin pointer = requester 0, so requester 0 has top priority first.
- Reset mid-transaction: immediately IDLE, m_en_o=0, gnt_o=0, no done_o. The master is not reset by this block.
- IDLE:
  - If any req_i is set and m_busy_i=0, pick the first requester at or after the pointer (wrapping).
  - Register its wdata/wcnt/rcnt/mode into the m_* outputs, assert its gnt_o bit, go to LAUNCH.
  - Grant appears on the cycle after the qualifying req_i.
  - If m_busy_i=1 in IDLE (foreign or leftover transfer), wait.
- LAUNCH:
  - m_en_o=1 until m_busy_i is sampled 1, then m_en_o=0 in the next cycle; go to BUSY.
- BUSY:
  - On m_busy_i=0, capture m_rdata_i into rd_data_o and go to DONE.
- DONE (one cycle):
  - done_o[k]=1, gnt_o cleared in the same cycle.
  - Pointer = k+1 mod N_REQ; back to IDLE.
- Minimum turnaround: one IDLE cycle between done_o and the next grant.
- Payload is captured at grant. Requester inputs may change after gnt_o without effect.
- req_i dropped before grant: never served. req_i dropped after grant: the transaction still completes and done_o still pulses.
- req_i still high in the cycle after done_o: treated as a new request. Other pending requesters win first (fairness).
- Read data: rd_data_o updates only on completion and holds otherwise. rcnt=0 still produces a capture (don't-care value).
- Payload and counts pass through unmodified; no width arithmetic beyond the pointer wrap.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - A counter starts in LAUNCH.
  - If m_busy_i has not risen after TIMEOUT cycles: m_en_o=0, pulse err_o[k] (not done_o), clear gnt_o, advance pointer, return to IDLE.
  - The counter clears on every state entry.
- Not defined: no counter, err_o tied 0, LAUNCH waits indefinitely.

Decomposition:
- Package i2c_arb_pkg: state encoding (IDLE, LAUNCH, BUSY, DONE), default width constants, and a function returning the one-hot round-robin pick.
- Sub-module rr_pick: combinational; takes the req vector and pointer, returns a one-hot grant and a valid flag. It is reusable by other shared-resource arbiters in the helai IPs.

Test Plan:
- Single write: req_i=01, wdata=0x1A_3008_78, wcnt=4; master model busy for 100 cycles → m_wdata_o=0x1A300878, m_en_o high until busy, done_o=01 exactly once, gnt_o low afterwards.
- Simultaneous: req_i=11 from reset → requester 0 served first, then requester 1; done_o sequence 01 then 10.
- Fairness: requester 0 holds req high continuously, requester 1 raises req during requester 0's BUSY → next grant goes to requester 1.
- Read: requester 1 with mode=1, rcnt=1; model returns 0x56 → rd_data_o=0x56 in the done_o=10 cycle, held afterwards.
- Reset: rst_n low during BUSY → next cycle m_en_o=0, gnt_o=0, done_o=0; after release, requester 0 has priority.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT=16): model never asserts busy → err_o pulses after 16 LAUNCH cycles, no done_o, the next requester is granted.
